demux_load_ctrl: RTL and testbench
==================================

# demux_load_ctrl

Sequencer that streams DW-bit words from a valid/ready source into N lane registers, one lane per accepted word, in lane order 0..N-1. It drives the lane select and one-hot write enable for the existing `top_demux` lane router. It presents each completed row of N words to the array-side consumer with a valid/ack handshake, and repeats for a programmed number of rows. It sits between the operand fetch stream and the systolic-array edge buffers.

## Interface
- `DW`, 8, word width
- `N`, 8, lanes per row; any value ≥2, not required to be a power of two
- `SEL`, `$clog2(N)`, select width
- `RW`, 16, row-count width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that begins a job; honored only in IDLE
- `num_rows`  in  RW  rows in the job; latched on an accepted `start`
- `abort`  in  1  synchronous cancel; returns to IDLE from any state
- `in_valid`  in  1  source word valid
- `in_data`  in  DW  source word
- `in_ready`  out  1  controller accepts a word
- `select`  out  SEL  registered lane index for the demux
- `lane_bus`  out  DW*N  demux output; only lane `select` is nonzero
- `lane_we`  out  N  registered one-hot write strobe
- `row_valid`  out  1  full row written and awaiting ack
- `row_ack`  in  1  consumer has taken the row
- `busy`  out  1  high in LOAD and WAIT_ACK
- `done`  out  1  one-cycle pulse at job end

## Operation
- **State set:** IDLE, LOAD, WAIT_ACK.
- **IDLE:**
  - `in_ready`=0, `busy`=0.
  - `start` with `num_rows`≠0: latch `rows_left`=`num_rows`, `lane`=0, go to LOAD.
  - `start` with `num_rows`=0: pulse `done` next cycle, stay in IDLE.
- **LOAD:**
  - `in_ready`=1 (Moore, decoded from state only).
  - Accept condition: `in_valid`&&`in_ready`.
  - On accept, registered at the next edge:
    - `select`←`lane`
    - data register←`in_data`
    - `lane_we`←(1<<`lane`)
  - On accept, also update `lane`:
    - If `lane`=N-1: `lane`←0, go to WAIT_ACK.
    - Otherwise: `lane`←`lane`+1.
  - Without an accept, `lane_we`←0; `select` and the data register hold.
- **WAIT_ACK:**
  - `in_ready`=0, `row_valid`=1.
  - On `row_ack`, decrement `rows_left`:
    - If the old `rows_left`=1: go to IDLE and pulse `done`.
    - Otherwise: go to LOAD.
  - `row_ack` in any other state is ignored.
- **`abort`:** highest priority.
  - Next state is IDLE; `lane`, `rows_left`, `lane_we` and `row_valid` clear.
  - No `done` pulse.
  - A word presented in the same cycle as `abort` is not accepted (`in_ready` is forced 0 that cycle).
- **`start` outside IDLE** is ignored; `num_rows` is not re-latched.
- **`rows_left`** is RW bits wide and never underflows; a job of 2^RW−1 rows is legal.
- **`lane_bus`** is the combinational demux of the data register by `select`, gated to zero when `lane_we`=0.

## Timing
- **Reset values:** every output is 0. State=IDLE, `lane`=0, `rows_left`=0.
- **Word latency:** `lane_we`/`select`/`lane_bus` appear 1 cycle after the accepting edge.
- **`row_valid`** rises the cycle after the Nth accept, coincident with `lane_we[N-1]`.
- **`row_ack`** is accepted in the first cycle `row_valid` is high.
- **Peak throughput:** N+1 cycles per row (N accepts plus 1 WAIT_ACK cycle with immediate ack).
- **`done`** asserts the cycle after the final `row_ack`, concurrent with `busy`=0.
- **Reset mid-job:** all state and outputs clear immediately; a partial row is discarded.

## Structure
- Shared package `apt_ctrl_pkg` holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, WAIT_ACK=2'd2)
  - the default `DW`/`N`/`RW`
  - reusable by other array feeders
- One sub-module instance: `top_demux` (params `DW`, `N`), fed by the data register and `select` to produce `lane_bus`.
- Registered FSM, lane counter and row counter live in this module.

## Test plan
- **Single row:** `N`=8, `num_rows`=1, `in_valid` held high with data 0x10..0x17.
  - `lane_we` walks 0x01..0x80 on cycles 2..9.
  - `row_valid` on cycle 9; ack on cycle 9 → `done` on cycle 10.
- **Backpressure, 3 rows:** `row_ack` delayed 4 cycles per row.
  - `in_ready` stays 0 throughout WAIT_ACK.
  - Exactly 24 accepts, one `done`.
- **Non-power-of-two lanes:** `N`=5, `num_rows`=2.
  - `select` sequence 0,1,2,3,4,0,1,2,3,4; never reaches 5–7.
- **Zero rows:** `num_rows`=0 with `start`.
  - `done` pulses next cycle, `busy` stays 0, no `in_ready`.
- **Abort and start-while-busy:**
  - `abort` during LOAD after 3 words → IDLE next cycle, `lane_we`=0, no `done`.
  - A following job of 1 row starts at lane 0.
  - `start` pulsed while busy has no effect.
- **Async reset mid-row:** deassert `rst_n` during WAIT_ACK.
  - All outputs 0 immediately.
  - Ack arriving after reset is ignored.

Source files
------------

// File: rtl/apt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// apt_ctrl_pkg
// Shared definitions for the array-feeder controllers: load-sequencer state
// encoding and the default word width, lane count and row-count width.
// ---------------------------------------------------------------------------
package apt_ctrl_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_N  = 8;
    localparam int DEF_RW = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/top_demux.sv
// ---------------------------------------------------------------------------
// top_demux
// Lane router: places i_data on lane i_sel of the DW*N output bus; all other
// lanes, and every lane when i_en is low, read zero.
//   i_data  DW     word to route
//   i_sel   SEL    destination lane index
//   i_en    1      route enable
//   o_bus   DW*N   lane bus, lane k at bits [k*DW +: DW]
// ---------------------------------------------------------------------------
module top_demux #(
    parameter int DW  = 8,
    parameter int N   = 8,
    parameter int SEL = $clog2(N)
) (
    input  logic [DW-1:0]   i_data,
    input  logic [SEL-1:0]  i_sel,
    input  logic            i_en,
    output logic [DW*N-1:0] o_bus
);

    // Decode the lane index and steer the word onto exactly one lane.
    always_comb begin
        o_bus = {(DW*N){1'b0}};
        for (int i = 0; i < N; i++) begin
            if (i_en && (i_sel == SEL'(i))) begin
                o_bus[i*DW +: DW] = i_data;
            end else begin
                o_bus[i*DW +: DW] = {DW{1'b0}};
            end
        end
    end

endmodule

// File: rtl/demux_load_ctrl.sv
// ---------------------------------------------------------------------------
// demux_load_ctrl
// Streams words from a valid/ready source into N lanes in order 0..N-1,
// presents each completed row with a valid/ack handshake and repeats for a
// programmed number of rows.
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_rows     job start pulse and row count (latched in IDLE)
//   abort               synchronous cancel back to IDLE
//   in_valid/in_ready   source handshake, in_data the word
//   select, lane_we     registered lane index and one-hot write strobe
//   lane_bus            routed word, only lane 'select' nonzero
//   row_valid/row_ack   row handshake towards the array
//   busy, done          job activity and end-of-job pulse
// ---------------------------------------------------------------------------
module demux_load_ctrl
    import apt_ctrl_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int N   = DEF_N,
    parameter int SEL = $clog2(N),
    parameter int RW  = DEF_RW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RW-1:0]   num_rows,
    input  logic            abort,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic [SEL-1:0]  select,
    output logic [DW*N-1:0] lane_bus,
    output logic [N-1:0]    lane_we,
    output logic            row_valid,
    input  logic            row_ack,
    output logic            busy,
    output logic            done
);

    localparam logic [SEL-1:0] LAST_LANE = SEL'(N - 1);
    localparam logic [N-1:0]   WE_ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0]  ROWS_ONE  = {{(RW-1){1'b0}}, 1'b1};

    state_t         r_state;
    logic [SEL-1:0] r_lane;
    logic [RW-1:0]  r_rows_left;
    logic [SEL-1:0] r_select;
    logic [DW-1:0]  r_data;
    logic [N-1:0]   r_lane_we;
    logic           r_done;
    logic           w_accept;
    logic           w_lane_en;

    // abort masks in_ready in its own cycle so a concurrent word is never taken.
    assign in_ready  = (r_state == ST_LOAD) && !abort;
    assign w_accept  = in_valid && in_ready;
    assign row_valid = (r_state == ST_WAIT_ACK);
    assign busy      = (r_state != ST_IDLE);
    assign select    = r_select;
    assign lane_we   = r_lane_we;
    assign done      = r_done;
    assign w_lane_en = |r_lane_we;

    // Sequencer FSM with lane counter, row counter and registered lane outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lane      <= {SEL{1'b0}};
            r_rows_left <= {RW{1'b0}};
            r_select    <= {SEL{1'b0}};
            r_data      <= {DW{1'b0}};
            r_lane_we   <= {N{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_lane_we <= {N{1'b0}};
            r_done    <= 1'b0;
            if (abort) begin
                r_state     <= ST_IDLE;
                r_lane      <= {SEL{1'b0}};
                r_rows_left <= {RW{1'b0}};
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (num_rows != {RW{1'b0}}) begin
                                r_rows_left <= num_rows;
                                r_lane      <= {SEL{1'b0}};
                                r_state     <= ST_LOAD;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (w_accept) begin
                            r_select  <= r_lane;
                            r_data    <= in_data;
                            r_lane_we <= WE_ONE << r_lane;
                            if (r_lane == LAST_LANE) begin
                                r_lane  <= {SEL{1'b0}};
                                r_state <= ST_WAIT_ACK;
                            end else begin
                                r_lane <= r_lane + SEL'(1'b1);
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        // rows_left is at least 1 here, so the decrement cannot wrap.
                        if (row_ack) begin
                            r_rows_left <= r_rows_left - ROWS_ONE;
                            if (r_rows_left == ROWS_ONE) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    top_demux #(
        .DW (DW),
        .N  (N),
        .SEL(SEL)
    ) u_top_demux (
        .i_data(r_data),
        .i_sel (r_select),
        .i_en  (w_lane_en),
        .o_bus (lane_bus)
    );

endmodule

// File: tb/tb_demux_load_ctrl.sv
module tb_demux_load_ctrl;

    logic        clk;
    logic        rst_n;
    // N=8 instance
    logic        start, abort, in_valid, row_ack;
    logic [15:0] num_rows;
    logic [7:0]  in_data;
    logic        in_ready, row_valid, busy, done;
    logic [2:0]  select;
    logic [63:0] lane_bus;
    logic [7:0]  lane_we;
    // N=5 instance
    logic        s5_start, s5_abort, s5_in_valid, s5_row_ack;
    logic [15:0] s5_num_rows;
    logic [7:0]  s5_in_data;
    logic        s5_in_ready, s5_row_valid, s5_busy, s5_done;
    logic [2:0]  s5_select;
    logic [39:0] s5_lane_bus;
    logic [4:0]  s5_lane_we;

    int n_chk;
    int n_fail;

    demux_load_ctrl #(.DW(8), .N(8), .RW(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .select(select), .lane_bus(lane_bus),
        .lane_we(lane_we), .row_valid(row_valid), .row_ack(row_ack),
        .busy(busy), .done(done)
    );

    demux_load_ctrl #(.DW(8), .N(5), .RW(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(s5_start), .num_rows(s5_num_rows),
        .abort(s5_abort), .in_valid(s5_in_valid), .in_data(s5_in_data),
        .in_ready(s5_in_ready), .select(s5_select), .lane_bus(s5_lane_bus),
        .lane_we(s5_lane_we), .row_valid(s5_row_valid), .row_ack(s5_row_ack),
        .busy(s5_busy), .done(s5_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] nr;
        logic        iv;
        logic [7:0]  d;
        logic        ack;
        logic        e_rdy;
        logic [7:0]  e_we;
        logic [2:0]  e_sel;
        logic [63:0] e_bus;
        logic        e_rv;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [15:0] nr, input logic iv, input logic [7:0] d,
                       input logic ack, input logic e_rdy, input logic [7:0] e_we,
                       input logic [2:0] e_sel, input logic [63:0] e_bus, input logic e_rv,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.start = st; v.nr = nr; v.iv = iv; v.d = d; v.ack = ack;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_sel = e_sel; v.e_bus = e_bus;
        v.e_rv = e_rv; v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero8(input string tag);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, " lane_we"}, 64'(lane_we), 64'd0);
        chk({tag, " select"}, 64'(select), 64'd0);
        chk({tag, " lane_bus"}, lane_bus, 64'd0);
        chk({tag, " row_valid"}, 64'(row_valid), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int acc, dones, bad, wcnt, found;
        logic [2:0] sels[$];

        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; row_ack = 1'b0;
        num_rows = 16'd0; in_data = 8'd0;
        s5_start = 1'b0; s5_abort = 1'b0; s5_in_valid = 1'b0; s5_row_ack = 1'b0;
        s5_num_rows = 16'd0; s5_in_data = 8'd0;

        // ---------------- reset state ----------------
        #1;
        chk_all_zero8("reset");
        chk("reset s5 lane_we", 64'(s5_lane_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table: single row then zero-row job ----------------
        add(1'b1, 16'd1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 3'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (c >= 2)
                add(1'b0, 16'd0, 1'b1, 8'(8'h10 + c - 1), 1'b0, 1'b1, 8'(8'h01 << (c - 2)),
                    3'(c - 2), 64'(8'h10 + c - 2) << (8 * (c - 2)), 1'b0, 1'b1, 1'b0);
            else
                add(1'b0, 16'd0, 1'b1, 8'h10, 1'b0, 1'b1, 8'h00, 3'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        end
        add(1'b0, 16'd0, 1'b1, 8'h18, 1'b1, 1'b0, 8'h80, 3'd7, 64'h17 << 56, 1'b1, 1'b1, 1'b0);
        add(1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 64'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 64'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 64'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 64'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 64'd0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start; num_rows = vecs[i].nr; in_valid = vecs[i].iv;
            in_data = vecs[i].d; row_ack = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d lane_we", i), 64'(lane_we), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d select", i), 64'(select), 64'(vecs[i].e_sel));
            chk($sformatf("vec%0d lane_bus", i), lane_bus, vecs[i].e_bus);
            chk($sformatf("vec%0d row_valid", i), 64'(row_valid), 64'(vecs[i].e_rv));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].e_done));
        end

        // ---------------- backpressure: 3 rows, ack after 4 cycles ----------------
        @(negedge clk);
        start = 1'b1; num_rows = 16'd3; in_valid = 1'b0; row_ack = 1'b0;
        acc = 0; dones = 0; bad = 0; wcnt = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = 8'(cyc);
            #1;
            if (in_ready && in_valid) acc++;
            if (done) dones++;
            if (row_valid) begin
                if (in_ready) bad++;
                if (wcnt == 4) begin
                    row_ack = 1'b1; wcnt = 0;
                end else begin
                    row_ack = 1'b0; wcnt++;
                end
            end else begin
                row_ack = 1'b0; wcnt = 0;
            end
        end
        in_valid = 1'b0; row_ack = 1'b0;
        chk("bp accepts", 64'(acc), 64'd24);
        chk("bp done count", 64'(dones), 64'd1);
        chk("bp in_ready during wait", 64'(bad), 64'd0);

        // ---------------- N=5, 2 rows ----------------
        @(negedge clk);
        s5_start = 1'b1; s5_num_rows = 16'd2;
        dones = 0; bad = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            s5_start = 1'b0; s5_in_valid = 1'b1; s5_in_data = 8'(8'h40 + cyc);
            #1;
            if (s5_lane_we != 5'd0) begin
                sels.push_back(s5_select);
                if (s5_lane_we != (5'b00001 << s5_select)) bad++;
            end
            if (s5_done) dones++;
            s5_row_ack = s5_row_valid;
        end
        s5_in_valid = 1'b0; s5_row_ack = 1'b0;
        chk("n5 write count", 64'(sels.size()), 64'd10);
        foreach (sels[i]) chk($sformatf("n5 select[%0d]", i), 64'(sels[i]), 64'(i % 5));
        chk("n5 we/select mismatch count", 64'(bad), 64'd0);
        chk("n5 done count", 64'(dones), 64'd1);

        // ---------------- abort after 3 words ----------------
        @(negedge clk);
        start = 1'b1; num_rows = 16'd2; in_valid = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = 8'(8'h20 + cyc);
            #1;
            if (in_ready && in_valid) acc++;
        end
        chk("abort pre-accepts", 64'(acc), 64'd3);
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        chk("abort in_ready forced low", 64'(in_ready), 64'd0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort lane_we", 64'(lane_we), 64'd0);
        chk("abort row_valid", 64'(row_valid), 64'd0);
        dones = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (done) dones++;
            @(negedge clk);
            #1;
        end
        chk("abort no done", 64'(dones), 64'd0);

        // ---------------- new job after abort, start while busy ----------------
        start = 1'b1; num_rows = 16'd1; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        start = 1'b0; in_data = 8'h56;
        @(negedge clk);
        start = 1'b1; num_rows = 16'd5; in_data = 8'h57;
        #1;
        chk("restart first lane_we", 64'(lane_we), 64'h01);
        chk("restart first select", 64'(select), 64'd0);
        chk("restart first lane_bus", lane_bus, 64'h56);
        dones = 0; bad = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            start = 1'b0; in_data = 8'(8'h58 + cyc);
            #1;
            if (done) begin
                dones++;
                if (busy) bad++;
            end
            row_ack = row_valid;
        end
        in_valid = 1'b0; row_ack = 1'b0;
        chk("restart done count", 64'(dones), 64'd1);
        chk("restart busy at done", 64'(bad), 64'd0);
        chk("restart idle at end", 64'(busy), 64'd0);

        // ---------------- async reset during WAIT_ACK ----------------
        @(negedge clk);
        start = 1'b1; num_rows = 16'd2;
        found = 0;
        for (int cyc = 0; cyc < 30 && found == 0; cyc++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = 8'(8'h70 + cyc);
            #1;
            if (row_valid) found = 1;
        end
        chk("rst reached wait_ack", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero8("midreset");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; row_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        row_ack = 1'b0;
        #1;
        chk_all_zero8("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
